// File: rtl/alu_pkg.sv
// Shared definitions for the ALU front end: default widths, collector states,
// command codes for both modes and the operand-need classification.
package alu_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_CMD_WIDTH  = 4;
    localparam int DEFAULT_TIMEOUT    = 16;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        NEED_A  = 2'd0,
        NEED_B  = 2'd1,
        NEED_AB = 2'd2,
        ILLEGAL = 2'd3
    } need_e;

    // Arithmetic mode (mode = 1)
    localparam int unsigned ARITH_ADD     = 0;
    localparam int unsigned ARITH_SUB     = 1;
    localparam int unsigned ARITH_ADD_CIN = 2;
    localparam int unsigned ARITH_SUB_CIN = 3;
    localparam int unsigned ARITH_INC_A   = 4;
    localparam int unsigned ARITH_DEC_A   = 5;
    localparam int unsigned ARITH_INC_B   = 6;
    localparam int unsigned ARITH_DEC_B   = 7;
    localparam int unsigned ARITH_CMP     = 8;
    localparam int unsigned ARITH_INC_MUL = 9;
    localparam int unsigned ARITH_SHL_MUL = 10;

    // Logical mode (mode = 0)
    localparam int unsigned LOG_AND     = 0;
    localparam int unsigned LOG_NAND    = 1;
    localparam int unsigned LOG_OR      = 2;
    localparam int unsigned LOG_NOR     = 3;
    localparam int unsigned LOG_XOR     = 4;
    localparam int unsigned LOG_XNOR    = 5;
    localparam int unsigned LOG_NOT_A   = 6;
    localparam int unsigned LOG_NOT_B   = 7;
    localparam int unsigned LOG_SHR1_A  = 8;
    localparam int unsigned LOG_SHL1_A  = 9;
    localparam int unsigned LOG_SHR1_B  = 10;
    localparam int unsigned LOG_SHL1_B  = 11;
    localparam int unsigned LOG_ROL_A_B = 12;
    localparam int unsigned LOG_ROR_A_B = 13;

endpackage

// File: rtl/alu_cmd_decode.sv
// Classifies mode/cmd into the operand set the operation consumes.
// Purely combinational; no latency, no backpressure.
module alu_cmd_decode
    import alu_pkg::*;
#(
    parameter int CMD_WIDTH = DEFAULT_CMD_WIDTH
) (
    input  logic                 mode,
    input  logic [CMD_WIDTH-1:0] cmd,
    output need_e                need
);

    logic [31:0] code;
    assign code = 32'(cmd);

    always_comb begin
        need = ILLEGAL;
        if (mode) begin
            case (code)
                ARITH_ADD, ARITH_SUB, ARITH_ADD_CIN, ARITH_SUB_CIN,
                ARITH_CMP, ARITH_INC_MUL, ARITH_SHL_MUL: need = NEED_AB;
                ARITH_INC_A, ARITH_DEC_A:                need = NEED_A;
                ARITH_INC_B, ARITH_DEC_B:                need = NEED_B;
                default:                                 need = ILLEGAL;
            endcase
        end else begin
            case (code)
                LOG_AND, LOG_NAND, LOG_OR, LOG_NOR, LOG_XOR, LOG_XNOR,
                LOG_ROL_A_B, LOG_ROR_A_B:                need = NEED_AB;
                LOG_NOT_A, LOG_SHR1_A, LOG_SHL1_A:       need = NEED_A;
                LOG_NOT_B, LOG_SHR1_B, LOG_SHL1_B:       need = NEED_B;
                default:                                 need = ILLEGAL;
            endcase
        end
    end

endmodule

// File: rtl/alu_operand_collector.sv
// Collects operands arriving in different cycles and issues one complete ALU op.
// Latency 1 cycle from completing input to issue_valid/err; ce=0 freezes state.
module alu_operand_collector
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int CMD_WIDTH  = DEFAULT_CMD_WIDTH,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT,
    parameter int CNT_WIDTH  = $clog2(TIMEOUT + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic                  mode,
    input  logic [CMD_WIDTH-1:0]  cmd,
    input  logic                  cin,
    input  logic [1:0]            inp_valid,
    input  logic [DATA_WIDTH-1:0] opa,
    input  logic [DATA_WIDTH-1:0] opb,
    output logic                  issue_valid,
    output logic [DATA_WIDTH-1:0] issue_opa,
    output logic [DATA_WIDTH-1:0] issue_opb,
    output logic [CMD_WIDTH-1:0]  issue_cmd,
    output logic                  issue_mode,
    output logic                  issue_cin,
    output logic                  busy,
    output logic                  err,
    output logic [CNT_WIDTH-1:0]  wait_cnt
);

    need_e need;

    alu_cmd_decode #(.CMD_WIDTH(CMD_WIDTH)) u_decode (
        .mode (mode),
        .cmd  (cmd),
        .need (need)
    );

    state_e                state_q, state_d;
    logic [1:0]            have_q, have_d;
    logic [DATA_WIDTH-1:0] col_opa_q, col_opa_d, col_opb_q, col_opb_d;
    logic [CMD_WIDTH-1:0]  col_cmd_q, col_cmd_d;
    logic                  col_mode_q, col_mode_d, col_cin_q, col_cin_d;
    logic [CNT_WIDTH-1:0]  wait_cnt_q, wait_cnt_d;
    logic                  issue_valid_q, issue_valid_d, err_q, err_d;
    logic [DATA_WIDTH-1:0] issue_opa_q, issue_opa_d, issue_opb_q, issue_opb_d;
    logic [CMD_WIDTH-1:0]  issue_cmd_q, issue_cmd_d;
    logic                  issue_mode_q, issue_mode_d, issue_cin_q, issue_cin_d;

    always_comb begin
        state_d       = state_q;
        have_d        = have_q;
        col_opa_d     = col_opa_q;
        col_opb_d     = col_opb_q;
        col_cmd_d     = col_cmd_q;
        col_mode_d    = col_mode_q;
        col_cin_d     = col_cin_q;
        wait_cnt_d    = wait_cnt_q;
        issue_valid_d = 1'b0;
        err_d         = 1'b0;
        issue_opa_d   = issue_opa_q;
        issue_opb_d   = issue_opb_q;
        issue_cmd_d   = issue_cmd_q;
        issue_mode_d  = issue_mode_q;
        issue_cin_d   = issue_cin_q;

        if (ce) begin
            case (state_q)
                IDLE: begin
                    if (inp_valid != 2'b00) begin
                        // Complete requests issue directly; an operand not supplied reads as zero.
                        if ((need == ILLEGAL) ||
                            (need == NEED_A && !inp_valid[0]) ||
                            (need == NEED_B && !inp_valid[1])) begin
                            err_d = 1'b1;
                        end else if (need != NEED_AB || inp_valid == 2'b11) begin
                            issue_valid_d = 1'b1;
                            issue_opa_d   = inp_valid[0] ? opa : '0;
                            issue_opb_d   = inp_valid[1] ? opb : '0;
                            issue_cmd_d   = cmd;
                            issue_mode_d  = mode;
                            issue_cin_d   = cin;
                        end else begin
                            col_opa_d  = opa;
                            col_opb_d  = opb;
                            col_cmd_d  = cmd;
                            col_mode_d = mode;
                            col_cin_d  = cin;
                            have_d     = inp_valid;
                            wait_cnt_d = '0;
                            state_d    = WAIT;
                        end
                    end
                end
                WAIT: begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                    if (inp_valid[0]) col_opa_d = opa;
                    if (inp_valid[1]) col_opb_d = opb;
                    // Arrival of the missing operand wins over an expiring timeout.
                    if ((inp_valid & ~have_q) != 2'b00) begin
                        issue_valid_d = 1'b1;
                        issue_opa_d   = col_opa_d;
                        issue_opb_d   = col_opb_d;
                        issue_cmd_d   = col_cmd_q;
                        issue_mode_d  = col_mode_q;
                        issue_cin_d   = col_cin_q;
                        have_d        = 2'b00;
                        state_d       = IDLE;
                    end else if (wait_cnt_q == CNT_WIDTH'(TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        have_d  = 2'b00;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            have_q        <= 2'b00;
            col_opa_q     <= '0;
            col_opb_q     <= '0;
            col_cmd_q     <= '0;
            col_mode_q    <= 1'b0;
            col_cin_q     <= 1'b0;
            wait_cnt_q    <= '0;
            issue_valid_q <= 1'b0;
            err_q         <= 1'b0;
            issue_opa_q   <= '0;
            issue_opb_q   <= '0;
            issue_cmd_q   <= '0;
            issue_mode_q  <= 1'b0;
            issue_cin_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            have_q        <= have_d;
            col_opa_q     <= col_opa_d;
            col_opb_q     <= col_opb_d;
            col_cmd_q     <= col_cmd_d;
            col_mode_q    <= col_mode_d;
            col_cin_q     <= col_cin_d;
            wait_cnt_q    <= wait_cnt_d;
            issue_valid_q <= issue_valid_d;
            err_q         <= err_d;
            issue_opa_q   <= issue_opa_d;
            issue_opb_q   <= issue_opb_d;
            issue_cmd_q   <= issue_cmd_d;
            issue_mode_q  <= issue_mode_d;
            issue_cin_q   <= issue_cin_d;
        end
    end

    assign issue_valid = issue_valid_q;
    assign issue_opa   = issue_opa_q;
    assign issue_opb   = issue_opb_q;
    assign issue_cmd   = issue_cmd_q;
    assign issue_mode  = issue_mode_q;
    assign issue_cin   = issue_cin_q;
    assign busy        = (state_q == WAIT);
    assign err         = err_q;
    assign wait_cnt    = wait_cnt_q;

endmodule

// File: tb/tb_alu_operand_collector.sv
// Directed bench for alu_operand_collector with hand-computed expectations.
module tb_alu_operand_collector;

    logic       clk = 1'b0;
    logic       rst;
    logic       ce;
    logic       mode;
    logic [3:0] cmd;
    logic       cin;
    logic [1:0] inp_valid;
    logic [7:0] opa, opb;
    logic       issue_valid;
    logic [7:0] issue_opa, issue_opb;
    logic [3:0] issue_cmd;
    logic       issue_mode, issue_cin, busy, err;
    logic [4:0] wait_cnt;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_operand_collector dut (
        .clk         (clk),
        .rst         (rst),
        .ce          (ce),
        .mode        (mode),
        .cmd         (cmd),
        .cin         (cin),
        .inp_valid   (inp_valid),
        .opa         (opa),
        .opb         (opb),
        .issue_valid (issue_valid),
        .issue_opa   (issue_opa),
        .issue_opb   (issue_opb),
        .issue_cmd   (issue_cmd),
        .issue_mode  (issue_mode),
        .issue_cin   (issue_cin),
        .busy        (busy),
        .err         (err),
        .wait_cnt    (wait_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic m, input logic [3:0] c, input logic ci,
                       input logic [1:0] v, input logic [7:0] a, input logic [7:0] b);
        mode = m; cmd = c; cin = ci; inp_valid = v; opa = a; opb = b;
    endtask

    initial begin
        rst = 1'b0; ce = 1'b1;
        req(1'b0, 4'd0, 1'b0, 2'b00, 8'h00, 8'h00);
        cyc(); cyc();
        chk("rst_issue_valid", 32'(issue_valid), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_wait_cnt", 32'(wait_cnt), 0);
        chk("rst_issue_opa", 32'(issue_opa), 0);
        rst = 1'b1;
        cyc();

        // Both operands together
        req(1'b1, 4'd0, 1'b0, 2'b11, 8'h12, 8'h34);
        cyc();
        chk("t1_issue_valid", 32'(issue_valid), 1);
        chk("t1_opa", 32'(issue_opa), 32'h12);
        chk("t1_opb", 32'(issue_opb), 32'h34);
        chk("t1_err", 32'(err), 0);
        inp_valid = 2'b00;
        cyc();
        chk("t1_pulse_drop", 32'(issue_valid), 0);
        chk("t1_hold_opa", 32'(issue_opa), 32'h12);

        // Back-to-back complete requests
        req(1'b1, 4'd1, 1'b1, 2'b11, 8'h01, 8'h02);
        cyc();
        chk("b2b_valid0", 32'(issue_valid), 1);
        chk("b2b_cin0", 32'(issue_cin), 1);
        req(1'b0, 4'd4, 1'b0, 2'b11, 8'h03, 8'h04);
        cyc();
        chk("b2b_valid1", 32'(issue_valid), 1);
        chk("b2b_opa1", 32'(issue_opa), 32'h03);
        chk("b2b_cmd1", 32'(issue_cmd), 4);
        chk("b2b_mode1", 32'(issue_mode), 0);
        chk("b2b_cin1", 32'(issue_cin), 0);

        // Split arrival: A first, B after 3 idle wait cycles
        req(1'b1, 4'd0, 1'b0, 2'b01, 8'hAA, 8'h00);
        cyc();
        chk("t2_busy0", 32'(busy), 1);
        chk("t2_cnt0", 32'(wait_cnt), 0);
        chk("t2_nv0", 32'(issue_valid), 0);
        req(1'b0, 4'd5, 1'b1, 2'b00, 8'h00, 8'h00);
        for (int i = 1; i <= 3; i++) begin
            cyc();
            chk("t2_busy", 32'(busy), 1);
            chk("t2_cnt", 32'(wait_cnt), 32'(i));
        end
        chk("t2_hold_old_opa", 32'(issue_opa), 32'h03);
        inp_valid = 2'b10; opb = 8'h55;
        cyc();
        chk("t2_issue_valid", 32'(issue_valid), 1);
        chk("t2_opa", 32'(issue_opa), 32'hAA);
        chk("t2_opb", 32'(issue_opb), 32'h55);
        chk("t2_cmd", 32'(issue_cmd), 0);
        chk("t2_mode", 32'(issue_mode), 1);
        chk("t2_cin", 32'(issue_cin), 0);
        chk("t2_busy_drop", 32'(busy), 0);
        inp_valid = 2'b00;

        // Timeout: B latched, A never arrives
        req(1'b0, 4'd12, 1'b0, 2'b10, 8'h00, 8'h77);
        cyc();
        chk("t3_busy0", 32'(busy), 1);
        inp_valid = 2'b00;
        for (int i = 1; i <= 15; i++) begin
            cyc();
            chk("t3_busy", 32'(busy), 1);
            chk("t3_no_err", 32'(err), 0);
        end
        chk("t3_cnt15", 32'(wait_cnt), 15);
        cyc();
        chk("t3_err", 32'(err), 1);
        chk("t3_no_issue", 32'(issue_valid), 0);
        chk("t3_busy_drop", 32'(busy), 0);
        cyc();
        chk("t3_err_pulse", 32'(err), 0);

        // Arrival on the 16th wait cycle beats the timeout
        req(1'b0, 4'd12, 1'b0, 2'b10, 8'h00, 8'h66);
        cyc();
        inp_valid = 2'b00;
        for (int i = 1; i <= 15; i++) cyc();
        chk("t4_still_busy", 32'(busy), 1);
        inp_valid = 2'b01; opa = 8'h0F;
        cyc();
        chk("t4_issue_valid", 32'(issue_valid), 1);
        chk("t4_no_err", 32'(err), 0);
        chk("t4_opa", 32'(issue_opa), 32'h0F);
        chk("t4_opb", 32'(issue_opb), 32'h66);
        chk("t4_cmd", 32'(issue_cmd), 12);
        inp_valid = 2'b00;

        // Overwrite of an already-latched operand while waiting
        req(1'b1, 4'd1, 1'b0, 2'b01, 8'h11, 8'h00);
        cyc();
        opa = 8'h22;
        cyc();
        chk("ow_busy", 32'(busy), 1);
        chk("ow_no_issue", 32'(issue_valid), 0);
        inp_valid = 2'b10; opb = 8'h33;
        cyc();
        chk("ow_valid", 32'(issue_valid), 1);
        chk("ow_opa", 32'(issue_opa), 32'h22);
        chk("ow_opb", 32'(issue_opb), 32'h33);

        // Illegal / wrong-operand / single-operand cases
        req(1'b1, 4'd4, 1'b0, 2'b10, 8'h00, 8'h01);
        cyc();
        chk("t5_wrong_op_err", 32'(err), 1);
        chk("t5_wrong_op_nv", 32'(issue_valid), 0);
        chk("t5_wrong_op_busy", 32'(busy), 0);
        req(1'b0, 4'd15, 1'b0, 2'b11, 8'h01, 8'h02);
        cyc();
        chk("t5_illegal_log", 32'(err), 1);
        req(1'b1, 4'd11, 1'b0, 2'b01, 8'h01, 8'h02);
        cyc();
        chk("t5_illegal_arith", 32'(err), 1);
        chk("t5_illegal_busy", 32'(busy), 0);
        req(1'b0, 4'd6, 1'b0, 2'b01, 8'h5A, 8'h00);
        cyc();
        chk("t5_single_valid", 32'(issue_valid), 1);
        chk("t5_single_err", 32'(err), 0);
        chk("t5_single_opa", 32'(issue_opa), 32'h5A);
        chk("t5_single_cmd", 32'(issue_cmd), 6);

        // ce freeze mid-wait, then asynchronous reset
        req(1'b1, 4'd2, 1'b1, 2'b01, 8'hC3, 8'h00);
        cyc();
        inp_valid = 2'b00;
        for (int i = 1; i <= 5; i++) cyc();
        chk("t6_cnt5", 32'(wait_cnt), 5);
        ce = 1'b0; inp_valid = 2'b10; opb = 8'h99;
        for (int i = 1; i <= 3; i++) begin
            cyc();
            chk("t6_frozen_cnt", 32'(wait_cnt), 5);
            chk("t6_frozen_busy", 32'(busy), 1);
            chk("t6_frozen_nv", 32'(issue_valid), 0);
        end
        ce = 1'b1; inp_valid = 2'b00;
        rst = 1'b0;
        #1;
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_cnt", 32'(wait_cnt), 0);
        chk("t6_rst_opa", 32'(issue_opa), 0);
        chk("t6_rst_cmd", 32'(issue_cmd), 0);
        chk("t6_rst_valid", 32'(issue_valid), 0);
        cyc();
        rst = 1'b1;
        cyc();
        chk("t6_no_stale_issue", 32'(issue_valid), 0);
        req(1'b0, 4'd0, 1'b0, 2'b11, 8'hF0, 8'h0F);
        cyc();
        chk("t6_new_valid", 32'(issue_valid), 1);
        chk("t6_new_opa", 32'(issue_opa), 32'hF0);
        chk("t6_new_opb", 32'(issue_opb), 32'h0F);
        inp_valid = 2'b00;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
